// File: rtl/lms_filter_tdm.sv
// rtl/lms_filter_tdm.sv - time-multiplexed multi-tap LMS / sign-error LMS adaptive FIR
module lms_filter_tdm #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 15,
    parameter int TAPS  = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [WIDTH-1:0]    din,
    input  logic signed [WIDTH-1:0]    desired,
    input  logic signed [WIDTH-1:0]    step_size,
    input  logic                       mode,
    input  logic                       adapt_en,
    input  logic                       weights_clr,
    output logic signed [WIDTH-1:0]    dout,
    output logic signed [WIDTH-1:0]    error,
    output logic                       out_valid,
    output logic                       busy,
    output logic [TAPS-1:0][WIDTH-1:0] weights
);
    // PW: raw product, AW: accumulator with headroom for TAPS products, SW: widest signed temp
    localparam int PW = 2 * WIDTH;
    localparam int AW = 2 * WIDTH + $clog2(TAPS);
    localparam int SW = AW + 1;
    localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILTER,
        S_ERR,
        S_UPDATE
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic signed [WIDTH-1:0] x_q [TAPS];
    logic signed [WIDTH-1:0] w_q [TAPS];
    logic signed [AW-1:0]    acc;
    logic signed [WIDTH-1:0] d_q;
    logic signed [WIDTH-1:0] mu_q;
    logic signed [WIDTH-1:0] mu_e_q;
    logic                    mode_q;
    logic                    adapt_q;

    logic signed [WIDTH-1:0] x_k;
    logic signed [WIDTH-1:0] w_k;
    logic signed [WIDTH-1:0] mul_a;
    logic signed [WIDTH-1:0] mul_b;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    prod_shr;
    logic signed [SW-1:0]    prod_x;
    logic signed [AW-1:0]    prod_acc;
    logic signed [AW-1:0]    acc_shr;
    logic signed [WIDTH-1:0] y_val;
    logic signed [SW-1:0]    e_wide;
    logic signed [WIDTH-1:0] e_val;
    logic signed [SW-1:0]    neg_mu;
    logic signed [WIDTH-1:0] mu_e_val;
    logic signed [WIDTH-1:0] w_upd;

    function automatic logic signed [SW-1:0] ext_w(input logic signed [WIDTH-1:0] v);
        return {{(SW - WIDTH){v[WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [SW-1:0] ext_p(input logic signed [PW-1:0] v);
        return {{(SW - PW){v[PW-1]}}, v};
    endfunction

    // Clamp to the WIDTH-bit signed range: in range only when all bits above the sign agree with it
    function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        logic [SW-WIDTH:0] top;
        top = v[SW-1:WIDTH-1];
        if (top == '0 || top == '1) begin
            return v[WIDTH-1:0];
        end else if (v[SW-1]) begin
            return {1'b1, {(WIDTH - 1){1'b0}}};
        end else begin
            return {1'b0, {(WIDTH - 1){1'b1}}};
        end
    endfunction

    assign in_ready = (state == S_IDLE) && !weights_clr;
    assign busy     = (state != S_IDLE);

    for (genvar g = 0; g < TAPS; g++) begin : g_weights
        assign weights[g] = w_q[g];
    end

    // Shared datapath: one multiplier serves the MAC (FILTER), mu*e (ERR) and mu_e*x (UPDATE)
    always_comb begin
        x_k     = x_q[cnt];
        w_k     = w_q[cnt];
        acc_shr = acc >>> FRAC;
        y_val   = sat({acc_shr[AW-1], acc_shr});
        e_wide  = ext_w(d_q) - ext_w(y_val);
        e_val   = sat(e_wide);
        mul_a   = w_k;
        mul_b   = x_k;
        if (state == S_ERR) begin
            mul_a = mu_q;
            mul_b = e_val;
        end else if (state == S_UPDATE) begin
            mul_a = mu_e_q;
        end
        // Sign-extended operands make the low PW bits of the product the exact signed result
        prod     = {{WIDTH{mul_a[WIDTH-1]}}, mul_a} * {{WIDTH{mul_b[WIDTH-1]}}, mul_b};
        prod_acc = AW'(prod);
        prod_shr = prod >>> FRAC;
        prod_x   = ext_p(prod_shr);
        neg_mu   = -ext_w(mu_q);
        if (!mode_q) begin
            mu_e_val = sat(prod_x);
        end else if (e_val == '0) begin
            mu_e_val = '0;
        end else if (e_val[WIDTH-1]) begin
            mu_e_val = sat(neg_mu);
        end else begin
            mu_e_val = mu_q;
        end
        w_upd = sat(ext_w(w_k) + prod_x);
    end

    // Control FSM and all datapath registers; reset aborts any sample in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            d_q       <= '0;
            mu_q      <= '0;
            mu_e_q    <= '0;
            mode_q    <= 1'b0;
            adapt_q   <= 1'b0;
            dout      <= '0;
            error     <= '0;
            out_valid <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                w_q[k] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (weights_clr) begin
                        for (int k = 0; k < TAPS; k++) begin
                            x_q[k] <= '0;
                            w_q[k] <= '0;
                        end
                    end else if (in_valid) begin
                        x_q[0] <= din;
                        for (int k = 1; k < TAPS; k++) begin
                            x_q[k] <= x_q[k-1];
                        end
                        d_q     <= desired;
                        mu_q    <= step_size;
                        mode_q  <= mode;
                        adapt_q <= adapt_en;
                        acc     <= '0;
                        cnt     <= '0;
                        state   <= S_FILTER;
                    end
                end
                S_FILTER: begin
                    acc <= acc + prod_acc;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= S_ERR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_ERR: begin
                    dout      <= y_val;
                    error     <= e_val;
                    out_valid <= 1'b1;
                    mu_e_q    <= mu_e_val;
                    state     <= adapt_q ? S_UPDATE : S_IDLE;
                end
                S_UPDATE: begin
                    w_q[cnt] <= w_upd;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
